// File: rtl/stack_rpn_ctrl.sv
// stack_rpn_ctrl: RPN command sequencer driving an external 16-bit stack through push/pop strobes.
module stack_rpn_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_imm,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [15:0] stk_data,
  input  logic [15:0] stk_top,
  input  logic [4:0]  stk_ptr,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam logic [2:0] OP_PUSHI = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_DROP  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;
  typedef enum logic [2:0] {IDLE, POPB, POPA, CAPA, EXEC, PUSH} state_t;
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, b_q, res_q, res_d, alu;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [4:0]  need;
  assign need = (cmd_op == OP_DROP) ? 5'd1 : 5'd2;
  assign alu = (op_q == OP_ADD) ? a_q + b_q :
               (op_q == OP_SUB) ? a_q - b_q :
               (op_q == OP_AND) ? a_q & b_q :
               (op_q == OP_OR)  ? a_q | b_q : a_q ^ b_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        op_d = cmd_op;
        if (cmd_op == OP_ILL) {err_d, code_d} = 3'b111;
        else if (cmd_op == OP_PUSHI) begin
          if (stk_ptr == 5'd31) {err_d, code_d} = 3'b110;
          else begin
            state_d = PUSH;
            res_d   = cmd_imm;
          end
        end
        else if (stk_ptr < need) {err_d, code_d} = 3'b101;
        else state_d = POPB;
      end
      POPB: state_d = (op_q == OP_DROP) ? IDLE : POPA;
      POPA: state_d = CAPA;
      CAPA: state_d = EXEC;
      EXEC: begin
        res_d   = alu;
        state_d = PUSH;
      end
      PUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // stk_top shows each popped element one cycle after its pop strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= (state_q == CAPA) ? stk_top : a_q;
      b_q     <= (state_q == POPA) ? stk_top : b_q;
      res_q   <= res_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end
  assign cmd_ready = (state_q == IDLE);
  assign stk_push  = (state_q == PUSH);
  assign stk_pop   = (state_q == POPB) || (state_q == POPA);
  assign stk_data  = stk_push ? res_q : '0;
  assign res_valid = stk_push;
  assign res_data  = res_q;
  assign err       = err_q;
  assign err_code  = code_q;
endmodule

// File: tb/tb_stack_rpn_ctrl.sv
// tb_stack_rpn_ctrl: directed bench with a behavioural external stack and push/result/error scoreboards.
module tb_stack_rpn_ctrl;
  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, stk_push, stk_pop, res_valid, err;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_imm, stk_data, stk_top, res_data;
  logic [4:0]  stk_ptr;
  logic [1:0]  err_code;
  logic [15:0] mem [32];
  logic [4:0]  sp, ld_val;
  logic        ld;
  logic [15:0] push_q[$], res_q[$];
  logic [1:0]  err_q[$];
  int checks = 0, errors = 0, push_cnt = 0, pop_cnt = 0, lat, p0;

  stack_rpn_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data(stk_data), .stk_top(stk_top), .stk_ptr(stk_ptr),
    .res_valid(res_valid), .res_data(res_data), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  assign stk_ptr = sp;

  always @(posedge clk) begin
    if (rst) sp <= '0;
    else if (ld) sp <= ld_val;
    else if (stk_push) begin
      mem[sp] <= stk_data;
      sp <= sp + 5'd1;
    end else if (stk_pop) begin
      stk_top <= mem[sp - 5'd1];
      sp <= sp - 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    logic [31:0] e;
    chk("push_pop_exclusive", {31'b0, stk_push & stk_pop}, 0);
    if (stk_pop) pop_cnt++;
    if (stk_push) begin
      push_cnt++;
      e = 'x;
      if (push_q.size() > 0) e = {16'b0, push_q.pop_front()};
      chk("push_data", {16'b0, stk_data}, e);
    end
    if (res_valid) begin
      e = 'x;
      if (res_q.size() > 0) e = {16'b0, res_q.pop_front()};
      chk("res_data", {16'b0, res_data}, e);
    end
    if (err) begin
      e = 'x;
      if (err_q.size() > 0) e = {30'b0, err_q.pop_front()};
      chk("err_code", {30'b0, err_code}, e);
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (n >= 50) chk("ready_timeout", {31'b0, cmd_ready}, 1);
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] imm, output int l);
    int n;
    wait_ready(n);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_ready(l);
  endtask

  task automatic expect_res(input logic [15:0] v);
    push_q.push_back(v);
    res_q.push_back(v);
  endtask

  task automatic load_sp(input logic [4:0] v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = v;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; ld = 1'b0; ld_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_push", {31'b0, stk_push}, 0);
    chk("rst_pop", {31'b0, stk_pop}, 0);
    chk("rst_data", {16'b0, stk_data}, 0);
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_res_data", {16'b0, res_data}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_err_code", {30'b0, err_code}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, cmd_ready}, 1);
    p0 = pop_cnt;
    expect_res(16'h0005); send(3'b000, 16'h0005, lat);
    chk("pushi_latency", lat, 2);
    expect_res(16'h0003); send(3'b000, 16'h0003, lat);
    expect_res(16'h0008); send(3'b001, 16'h0, lat);
    chk("binop_latency", lat, 6);
    chk("add_pops", pop_cnt - p0, 2);
    chk("add_res_hold", {16'b0, res_data}, 16'h0008);
    chk("add_sp", {27'b0, sp}, 1);
    p0 = pop_cnt;
    send(3'b110, 16'h0, lat);
    chk("drop_latency", lat, 2);
    chk("drop_pops", pop_cnt - p0, 1);
    chk("drop_sp", {27'b0, sp}, 0);
    chk("drop_res_hold", {16'b0, res_data}, 16'h0008);
    expect_res(16'h0001); send(3'b000, 16'h0001, lat);
    expect_res(16'h0002); send(3'b000, 16'h0002, lat);
    expect_res(16'hFFFF); send(3'b010, 16'h0, lat);
    chk("sub_wrap", {16'b0, res_data}, 16'hFFFF);
    expect_res(16'hF0F0); send(3'b000, 16'hF0F0, lat);
    expect_res(16'hF0F0); send(3'b011, 16'h0, lat);
    expect_res(16'h0FF0); send(3'b000, 16'h0FF0, lat);
    expect_res(16'hFFF0); send(3'b100, 16'h0, lat);
    expect_res(16'hFFFF); send(3'b000, 16'hFFFF, lat);
    expect_res(16'h000F); send(3'b101, 16'h0, lat);
    expect_res(16'hFFF5); send(3'b000, 16'hFFF5, lat);
    expect_res(16'h0004); send(3'b001, 16'h0, lat);
    chk("add_wrap", {16'b0, res_data}, 16'h0004);
    chk("chain_sp", {27'b0, sp}, 1);
    p0 = pop_cnt;
    err_q.push_back(2'b01); send(3'b001, 16'h0, lat);
    chk("one_elem_add_pops", pop_cnt - p0, 0);
    chk("one_elem_add_sp", {27'b0, sp}, 1);
    send(3'b110, 16'h0, lat);
    p0 = pop_cnt;
    err_q.push_back(2'b01); send(3'b001, 16'h0, lat);
    err_q.push_back(2'b01); send(3'b110, 16'h0, lat);
    chk("empty_pops", pop_cnt - p0, 0);
    chk("empty_latency", lat, 1);
    load_sp(5'd30);
    expect_res(16'h1111); send(3'b000, 16'h1111, lat);
    chk("fill_sp", {27'b0, sp}, 31);
    p0 = push_cnt;
    err_q.push_back(2'b10); send(3'b000, 16'h1234, lat);
    chk("full_pushes", push_cnt - p0, 0);
    chk("full_sp", {27'b0, sp}, 31);
    load_sp(5'd0);
    expect_res(16'h000A); send(3'b000, 16'h000A, lat);
    expect_res(16'h0014); send(3'b000, 16'h0014, lat);
    expect_res(16'h001E); expect_res(16'h0055);
    p0 = pop_cnt;
    wait_ready(lat);
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_imm = 16'h0;
    @(posedge clk);
    #1 cmd_op = 3'b000; cmd_imm = 16'h0055;
    wait_ready(lat);
    chk("held_valid_latency", lat, 6);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_ready(lat);
    chk("held_valid_pops", pop_cnt - p0, 2);
    chk("held_valid_sp", {27'b0, sp}, 2);
    p0 = pop_cnt;
    err_q.push_back(2'b11); send(3'b111, 16'h0, lat);
    repeat (3) @(negedge clk);
    chk("ill_code_held", {30'b0, err_code}, 2'b11);
    chk("ill_err_low", {31'b0, err}, 0);
    chk("ill_no_access", pop_cnt - p0, 0);
    wait_ready(lat);
    cmd_valid = 1'b1; cmd_op = 3'b001;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_push", {31'b0, stk_push}, 0);
    chk("abort_pop", {31'b0, stk_pop}, 0);
    chk("abort_res_valid", {31'b0, res_valid}, 0);
    chk("abort_res_data", {16'b0, res_data}, 0);
    chk("abort_err", {31'b0, err}, 0);
    chk("abort_err_code", {30'b0, err_code}, 0);
    chk("abort_stk_data", {16'b0, stk_data}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, cmd_ready}, 1);
    expect_res(16'h0042); send(3'b000, 16'h0042, lat);
    chk("post_abort_res", {16'b0, res_data}, 16'h0042);
    chk("post_abort_sp", {27'b0, sp}, 1);
    repeat (3) @(negedge clk);
    chk("push_q_drained", push_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
